// File: rtl/gate_selftest_pkg.sv
// -----------------------------------------------------------------------------
// gate_selftest_pkg
//   Shared definitions for the two-input gate bank self-test sequencer:
//   - state_t      : sequencer FSM states
//   - Y_*          : bit positions inside the gate bank's 7-bit y result
//   - expected_y() : golden response of a healthy gate bank for inputs (a,b)
// -----------------------------------------------------------------------------
package gate_selftest_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Width of the gate bank result bus and position of each gate in it.
  localparam int Y_W    = 7;
  localparam int Y_OR   = 0;
  localparam int Y_AND  = 1;
  localparam int Y_NOTA = 2;
  localparam int Y_XOR  = 3;
  localparam int Y_XNOR = 4;
  localparam int Y_NAND = 5;
  localparam int Y_NOR  = 6;

  // Settle and loop counters are sized for the 1..255 parameter range.
  localparam int CNT_W = 8;

  // Response of a fault-free gate bank.
  function automatic logic [Y_W-1:0] expected_y(input logic a, input logic b);
    logic [Y_W-1:0] y;
    y         = '0;
    y[Y_OR]   = a | b;
    y[Y_AND]  = a & b;
    y[Y_NOTA] = ~a;
    y[Y_XOR]  = a ^ b;
    y[Y_XNOR] = ~(a ^ b);
    y[Y_NAND] = ~(a & b);
    y[Y_NOR]  = ~(a | b);
    return y;
  endfunction

endpackage : gate_selftest_pkg

// File: rtl/gate_selftest_seq_golden.sv
// -----------------------------------------------------------------------------
// gate_golden
//   Purely combinational golden model of the two-input gate bank.
//   Ports:
//     a, b : gate bank inputs
//     y    : expected 7-bit result ([0]OR [1]AND [2]NOT a [3]XOR [4]XNOR
//            [5]NAND [6]NOR)
// -----------------------------------------------------------------------------
module gate_golden
  import gate_selftest_pkg::*;
(
  input  logic           a,
  input  logic           b,
  output logic [Y_W-1:0] y
);

  assign y = expected_y(a, b);

endmodule : gate_golden

// File: rtl/gate_selftest_seq.sv
// -----------------------------------------------------------------------------
// gate_selftest_seq
//   Self-test sequencer for the two-input gate bank. On an accepted start it
//   walks {a,b} through 00,01,10,11 (LOOPS times), holds each vector for
//   SETTLE_CYCLES clocks, samples the bank result y_i on the last held edge
//   and compares it against the golden model.
//
//   Parameters:
//     SETTLE_CYCLES : clocks each vector is held before sampling (1..255)
//     LOOPS         : full 4-vector passes per run (1..255)
//     ERR_W         : width of the saturating mismatch counter
//
//   Ports:
//     clk, rst_n      : clock (rising edge), async active-low reset
//     start           : run request, only honoured while idle
//     a_o, b_o        : registered drive into the gate bank
//     y_i             : gate bank result (synchronous to clk)
//     busy            : run in progress
//     done            : one-cycle pulse at end of run
//     pass            : last run had no mismatch (held until next start)
//     err_cnt         : mismatching samples in last run (saturating)
//     fail_mask       : bit {a,b} set if that vector ever mismatched
//     first_fail_vec  : {a,b} of the first mismatch
//     first_fail_bits : y_i ^ expected at the first mismatch
// -----------------------------------------------------------------------------
module gate_selftest_seq
  import gate_selftest_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic [Y_W-1:0]   y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_mask,
  output logic [1:0]       first_fail_vec,
  output logic [Y_W-1:0]   first_fail_bits
);

  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] LOOP_INIT   = CNT_W'(LOOPS);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;        // current {a,b}; drives a_o/b_o
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] loop_q, loop_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       mask_q, mask_d;
  logic [1:0]       ffv_q, ffv_d;
  logic [Y_W-1:0]   ffb_q, ffb_d;
  logic             pass_q, pass_d;

  logic [Y_W-1:0]   exp_y;
  logic [Y_W-1:0]   diff;
  logic             mismatch;
  logic             sample;

  gate_golden u_golden (
    .a (vec_q[1]),
    .b (vec_q[0]),
    .y (exp_y)
  );

  assign diff     = y_i ^ exp_y;
  assign mismatch = |diff;
  // The sample edge is the one on which the settle counter would reach 0.
  assign sample   = (state_q == RUN) && (settle_q == CNT_W'(1));

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    loop_d   = loop_q;
    err_d    = err_q;
    mask_d   = mask_q;
    ffv_d    = ffv_q;
    ffb_d    = ffb_q;
    pass_d   = pass_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          vec_d    = 2'b00;
          settle_d = SETTLE_INIT;
          loop_d   = LOOP_INIT;
          err_d    = '0;
          mask_d   = '0;
          ffv_d    = '0;
          ffb_d    = '0;
          pass_d   = 1'b0;
        end
      end

      RUN: begin
        settle_d = settle_q - CNT_W'(1);
        if (sample) begin
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_W'(1);
            end
            mask_d[vec_q] = 1'b1;
            // err_q is cleared at start and never wraps, so zero here means
            // this is the first mismatch of the run.
            if (err_q == '0) begin
              ffv_d = vec_q;
              ffb_d = diff;
            end
          end

          settle_d = SETTLE_INIT;
          vec_d    = vec_q + 2'd1;

          if (vec_q == 2'b11) begin
            if (loop_q == CNT_W'(1)) begin
              state_d = FINISH;
              vec_d   = 2'b00;
              // Final sample's result is folded in directly.
              pass_d  = (err_q == '0) && !mismatch;
            end else begin
              loop_d = loop_q - CNT_W'(1);
            end
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and result registers
  // ---------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, regardless of statement order.
  // NOTE: every register here is a plain flop (no memory arrays), so all of
  // them are cleared by the async reset to make outputs 0 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      loop_q   <= '0;
      err_q    <= '0;
      mask_q   <= '0;
      ffv_q    <= '0;
      ffb_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      loop_q   <= loop_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
      ffv_q    <= ffv_d;
      ffb_q    <= ffb_d;
      pass_q   <= pass_d;
    end
  end

  // busy/done decode straight from the state register, so they are glitch
  // free and drop together with the state on reset.
  assign a_o             = vec_q[1];
  assign b_o             = vec_q[0];
  assign busy            = (state_q == RUN);
  assign done            = (state_q == FINISH);
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign fail_mask       = mask_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_bits = ffb_q;

endmodule : gate_selftest_seq

// File: tb/tb_gate_selftest_seq.sv
// -----------------------------------------------------------------------------
// tb_gate_selftest_seq
//   Three sequencer instances share clk/rst_n:
//     0 : SETTLE=2 LOOPS=1   1 : SETTLE=2 LOOPS=5   2 : SETTLE=1 LOOPS=1
//   Each drives a behavioural gate bank whose fault mode is selectable:
//     0 ideal, 1 y[3] stuck at 0, 2 y stuck at 7'h00, 3 one-cycle delay.
//   Stimulus pushes the hand-computed end-of-run result into a scoreboard;
//   a monitor pops and compares whenever any instance pulses done.
// -----------------------------------------------------------------------------
module tb_gate_selftest_seq;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] start = '0;
  logic [NI-1:0] a_w, b_w, busy_w, done_w, pass_w;
  logic [3:0]    err_w  [NI];
  logic [3:0]    mask_w [NI];
  logic [1:0]    ffv_w  [NI];
  logic [6:0]    ffb_w  [NI];
  logic [6:0]    y_w    [NI];
  logic [6:0]    yd     [NI];
  int            mode   [NI];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  gate_selftest_seq #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a_o(a_w[0]), .b_o(b_w[0]),
    .y_i(y_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_cnt(err_w[0]), .fail_mask(mask_w[0]), .first_fail_vec(ffv_w[0]),
    .first_fail_bits(ffb_w[0]));

  gate_selftest_seq #(.SETTLE_CYCLES(2), .LOOPS(5), .ERR_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a_o(a_w[1]), .b_o(b_w[1]),
    .y_i(y_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_cnt(err_w[1]), .fail_mask(mask_w[1]), .first_fail_vec(ffv_w[1]),
    .first_fail_bits(ffb_w[1]));

  gate_selftest_seq #(.SETTLE_CYCLES(1), .LOOPS(1), .ERR_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .a_o(a_w[2]), .b_o(b_w[2]),
    .y_i(y_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_cnt(err_w[2]), .fail_mask(mask_w[2]), .first_fail_vec(ffv_w[2]),
    .first_fail_bits(ffb_w[2]));

  // ---------------------------------------------------------------------------
  // Behavioural gate bank
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] bank_y(input logic a, input logic b);
    logic [6:0] y;
    y[0] = a | b;
    y[1] = a & b;
    y[2] = !a;
    y[3] = a ^ b;
    y[4] = !(a ^ b);
    y[5] = !(a & b);
    y[6] = !(a | b);
    return y;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) yd[i] <= bank_y(a_w[i], b_w[i]);
  end

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      y_w[i] = bank_y(a_w[i], b_w[i]);
      case (mode[i])
        1:       y_w[i] = bank_y(a_w[i], b_w[i]) & 7'b1110111;
        2:       y_w[i] = 7'h00;
        3:       y_w[i] = yd[i];
        default: y_w[i] = bank_y(a_w[i], b_w[i]);
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         inst;
    logic       pass;
    logic [3:0] err;
    logic [3:0] mask;
    logic [1:0] ffv;
    logic [6:0] ffb;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (done_w[i]) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: instance %0d pulsed done at cycle %0d with no run pending", i, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("done_instance", i, mon_e.inst);
          check("done_cycle", cyc, mon_e.done_cyc);
          check("busy_at_done", {31'b0, busy_w[i]}, 0);
          check("pass", {31'b0, pass_w[i]}, {31'b0, mon_e.pass});
          check("err_cnt", {28'b0, err_w[i]}, {28'b0, mon_e.err});
          check("fail_mask", {28'b0, mask_w[i]}, {28'b0, mon_e.mask});
          check("first_fail_vec", {30'b0, ffv_w[i]}, {30'b0, mon_e.ffv});
          check("first_fail_bits", {25'b0, ffb_w[i]}, {25'b0, mon_e.ffb});
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at a negedge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse start for one cycle; the next posedge is E0. Done is expected at
  // the negedge following edge E0 + 4*settle*loops.
  task automatic issue(input int i, input logic p, input logic [3:0] err,
                       input logic [3:0] mask, input logic [1:0] ffv,
                       input logic [6:0] ffb, input int settle, input int loops);
    exp_t e;
    e.inst     = i;
    e.pass     = p;
    e.err      = err;
    e.mask     = mask;
    e.ffv      = ffv;
    e.ffb      = ffb;
    e.done_cyc = cyc + 1 + 4 * settle * loops;
    sb.push_back(e);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget, output int n);
    n = 0;
    while (busy_w[i] && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", {31'b0, busy_w[i]}, 0);
  endtask

  task automatic check_zero_outputs(input int i, input string tag);
    check({tag, "_ab"}, {30'b0, a_w[i], b_w[i]}, 0);
    check({tag, "_busy_done_pass"}, {29'b0, busy_w[i], done_w[i], pass_w[i]}, 0);
    check({tag, "_err_mask"}, {24'b0, err_w[i], mask_w[i]}, 0);
    check({tag, "_first_fail"}, {23'b0, ffv_w[i], ffb_w[i]}, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    logic [1:0] ev;
    for (int i = 0; i < NI; i++) mode[i] = 0;

    // Reset state
    repeat (3) tick();
    for (int i = 0; i < NI; i++) check_zero_outputs(i, "reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Healthy loopback: vectors step every 2 cycles, done at E0+8 for 1 cycle
    issue(0, 1'b1, 4'd0, 4'b0000, 2'b00, 7'b0000000, 2, 1);
    for (int k = 0; k < 8; k++) begin
      ev = 2'(k / 2);
      check("vector_step", {30'b0, a_w[0], b_w[0]}, {30'b0, ev});
      check("busy_in_run", {31'b0, busy_w[0]}, 1);
      tick();
    end
    check("ab_zero_at_done", {30'b0, a_w[0], b_w[0]}, 0);
    check("done_high", {31'b0, done_w[0]}, 1);
    tick();
    check("done_one_cycle", {31'b0, done_w[0]}, 0);
    tick();

    // XOR output stuck at 0: vectors 01 and 10 fail
    mode[0] = 1;
    tick();
    issue(0, 1'b0, 4'd2, 4'b0110, 2'b01, 7'b0001000, 2, 1);
    wait_idle(0, 20, n);
    repeat (4) tick();
    check("results_hold_err", {28'b0, err_w[0]}, 2);
    check("results_hold_pass", {31'b0, pass_w[0]}, 0);

    // All outputs stuck low over 5 loops: saturation at 15
    mode[1] = 2;
    tick();
    issue(1, 1'b0, 4'd15, 4'b1111, 2'b00, 7'b1110100, 2, 5);
    wait_idle(1, 60, n);
    repeat (2) tick();

    // start during RUN and during FINISH is ignored
    issue(0, 1'b0, 4'd2, 4'b0110, 2'b01, 7'b0001000, 2, 1);
    start[0] = 1'b1;
    repeat (3) tick();
    start[0] = 1'b0;
    wait_idle(0, 20, n);
    check("busy_profile_len", n, 5);
    start[0] = 1'b1;              // this cycle is FINISH
    tick();
    start[0] = 1'b0;
    check("finish_start_ignored", {31'b0, busy_w[0]}, 0);
    repeat (3) tick();
    check("no_rerun", {31'b0, busy_w[0]}, 0);

    // A later start from IDLE clears results and reruns cleanly
    mode[0] = 0;
    issue(0, 1'b1, 4'd0, 4'b0000, 2'b00, 7'b0000000, 2, 1);
    wait_idle(0, 20, n);
    repeat (2) tick();

    // Reset while vector 10 is driven: outputs clear at once, no done pulse
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (!(a_w[0] && !b_w[0]) && n < 20) begin
      tick();
      n++;
    end
    check("reached_vec_10", {30'b0, a_w[0], b_w[0]}, 2);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs(0, "midrun_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    issue(0, 1'b1, 4'd0, 4'b0000, 2'b00, 7'b0000000, 2, 1);
    wait_idle(0, 20, n);
    repeat (2) tick();

    // One-cycle-late bank: SETTLE=2 passes, SETTLE=1 sees the previous vector
    mode[0] = 3;
    mode[2] = 3;
    repeat (2) tick();
    issue(0, 1'b1, 4'd0, 4'b0000, 2'b00, 7'b0000000, 2, 1);
    wait_idle(0, 20, n);
    repeat (2) tick();
    issue(2, 1'b0, 4'd3, 4'b1110, 2'b01, 7'b1011001, 1, 1);
    wait_idle(2, 20, n);
    repeat (3) tick();

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_gate_selftest_seq

// File: doc/gate_selftest_seq.md
Name: gate_selftest_seq

Overview:
- Sequencer that exhaustively exercises the two-input gate bank: drives all four (a,b) vectors and captures the bank's 7-bit y result.
- Compares each captured y against an internal golden model and reports pass/fail, an error count and first-failure detail.
- Sits directly around the gate bank: its a/b outputs feed the bank, and the bank's y output feeds back to it. Used for power-on or bench self-test.

Parameters:
- SETTLE_CYCLES, 2, clocks each vector is held before y_i is sampled; legal range 1..255.
- LOOPS, 1, number of full 4-vector passes per run; legal range 1..255.
- ERR_W, 4, width of err_cnt; the counter saturates at 2^ERR_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only while busy=0.
- a_o  out  1  a input to the gate bank (registered).
- b_o  out  1  b input to the gate bank (registered).
- y_i  in  7  gate bank result: [0]OR [1]AND [2]NOT a [3]XOR [4]XNOR [5]NAND [6]NOR.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 when the last run had zero mismatches; held until the next start.
- err_cnt  out  ERR_W  number of mismatching samples in the last run; saturating.
- fail_mask  out  4  bit {a,b} set if that vector ever mismatched in the run.
- first_fail_vec  out  2  {a,b} of the first mismatch.
- first_fail_bits  out  7  y_i XOR expected at the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs go to 0 immediately.
  - FSM goes to IDLE; settle counter, vector index and loop counter clear.
  - Reset mid-run aborts the run; no done pulse is produced.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - start=1 at edge E0 moves the FSM to RUN and sets busy=1.
  - At the same edge, results clear (err_cnt, fail_mask, first_fail_*, pass all 0), vector index=0, a_o=b_o=0, settle counter=SETTLE_CYCLES, loop counter=LOOPS.
- RUN:
  - The settle counter decrements every edge.
  - On the edge where it would reach 0, y_i is sampled and compared with expected(a_o,b_o).
  - On that same edge the vector index increments mod 4, a_o/b_o update to the new index ({a,b} order 00,01,10,11), and the counter reloads.
  - Each vector is therefore held exactly SETTLE_CYCLES cycles. Samples occur at edges E0+k*SETTLE_CYCLES for k=1..4*LOOPS.
- Wrap: after sampling vector 11, the loop counter decrements. If loops remain, the sequence resumes at 00 with no gap cycle.
- Final sample (vector 11, last loop), all on one edge:
  - FSM moves to FINISH.
  - a_o=b_o=0.
  - done=1 and busy=0.
  - pass=(final err_cnt==0).
  - The final sample's compare result is included in err_cnt, pass and the other results.
- FINISH: lasts exactly one cycle, then returns to IDLE and done returns to 0. A start seen in this cycle is ignored.
- Total latency: done is visible after edge E0+4*SETTLE_CYCLES*LOOPS.
- Mismatch on a sample (y_i != expected):
  - err_cnt increments, saturating at max.
  - fail_mask[{a,b}] is set.
  - If this is the run's first mismatch, first_fail_vec and first_fail_bits are captured; later mismatches do not overwrite them.
- Golden model: expected = {~(a|b), ~(a&b), ~(a^b), a^b, ~a, a&b, a|b}, bit 6 down to bit 0.
- start while busy=1: ignored and not queued.
- Results (pass, err_cnt, fail_mask, first_fail_*) hold after done until the next accepted start.
- y_i is assumed synchronous to clk; no synchroniser is required.

Decomposition:
- Shared package gate_selftest_pkg:
  - state enum {IDLE, RUN, FINISH};
  - y bit-index constants (Y_OR=0 through Y_NOR=6);
  - function expected_y(a,b) returning 7 bits.
- Sub-module gate_golden: combinational golden model wrapping expected_y. It is reused by bench scoreboards.
- Counters, FSM and result registers stay in gate_selftest_seq.

Test Plan:
- Healthy loopback (ideal gate model, SETTLE=2, LOOPS=1), start at E0 -> a_o/b_o step 00,01,10,11 every 2 cycles. Response: done pulse after E0+8 for exactly 1 cycle, pass=1, err_cnt=0, fail_mask=0000.
- y_i[3] stuck at 0 -> err_cnt=2, fail_mask=0110, first_fail_vec=01, first_fail_bits=7'b0001000, pass=0.
- y_i stuck at 7'h00, LOOPS=5, ERR_W=4 -> 20 mismatches; err_cnt saturates at 15, fail_mask=1111, first_fail_vec=00, first_fail_bits=7'b1110100, done after E0+40.
- start re-asserted during RUN and during FINISH -> ignored: busy profile unchanged, single done pulse; a later start from IDLE clears results and reruns.
- rst_n low while vector 10 is driven -> all outputs 0 immediately, no done pulse; a subsequent start with a healthy model gives pass=1.
- Bank model with 1-cycle output delay: SETTLE=1 -> pass=0 and err_cnt>0; SETTLE=2 -> pass=1.
